// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and types for the serial-in parallel-out shift register
package sipo_pkg;

  // Width used when an instance does not override WIDTH
  localparam int SIPO_DEFAULT_WIDTH = 8;

  // Shift direction, named for readability at instantiation sites
  typedef enum logic {
    SHIFT_LEFT_E  = 1'b1,
    SHIFT_RIGHT_E = 1'b0
  } shift_dir_e;

endpackage : sipo_pkg

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - serial-in parallel-out shift register with synchronous parallel-load override
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int          WIDTH      = SIPO_DEFAULT_WIDTH,
  // 1: sin enters at bit 0 and moves toward the MSB; 0: sin enters at the MSB and moves toward bit 0
  parameter bit          SHIFT_LEFT = 1'b1,
  // Carried in a wide container so an out-of-range value can be caught at elaboration
  parameter logic [63:0] RESET_VAL  = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;

  // Parameter legality, rejected when the instance is elaborated
  generate
    if (WIDTH < 2) begin : g_width_check
      $error("sipo_shift_reg: WIDTH must be at least 2");
    end
    if ((RESET_VAL >> WIDTH) != 64'd0) begin : g_reset_val_check
      $error("sipo_shift_reg: RESET_VAL does not fit in WIDTH bits");
    end
  endgenerate

  // One update per rising edge: reset beats load, load beats shift; the far-end bit is dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= RESET_Q;
    end else if (load) begin
      r_q <= d;
    end else if (SHIFT_LEFT) begin
      r_q <= {r_q[WIDTH-2:0], sin};
    end else begin
      r_q <= {sin, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

  // Priority rules, checked one edge after the controls are sampled
  a_reset_wins : assert property (@(posedge clk) !reset |=> (q == RESET_Q))
    else $error("sipo_shift_reg: q did not take RESET_VAL after reset");

  a_load_wins : assert property (@(posedge clk) (reset && load) |=> (q == $past(d)))
    else $error("sipo_shift_reg: q did not take d after load");

  generate
    if (SHIFT_LEFT) begin : g_shift_left_prop
      a_shift : assert property (@(posedge clk) (reset && !load) |=>
                                 (q == {$past(q[WIDTH-2:0]), $past(sin)}))
        else $error("sipo_shift_reg: left shift result wrong");
    end else begin : g_shift_right_prop
      a_shift : assert property (@(posedge clk) (reset && !load) |=>
                                 (q == {$past(sin), $past(q[WIDTH-1:1])}))
        else $error("sipo_shift_reg: right shift result wrong");
    end
  endgenerate

endmodule : sipo_shift_reg

// File: tb/tb_sipo_shift_reg.sv
// tb/tb_sipo_shift_reg.sv - scoreboard bench for sipo_shift_reg, 8-bit left and 4-bit right instances
module tb_sipo_shift_reg;
  import sipo_pkg::*;

  localparam shift_dir_e B_DIR = SHIFT_RIGHT_E;

  logic       clk = 1'b0;

  logic       a_reset = 1'b0;
  logic       a_sin   = 1'b0;
  logic       a_load  = 1'b0;
  logic [7:0] a_d     = 8'h00;
  logic [7:0] a_q;

  logic       b_reset = 1'b0;
  logic       b_sin   = 1'b0;
  logic       b_load  = 1'b0;
  logic [3:0] b_d     = 4'h0;
  logic [3:0] b_q;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected q after each edge, with the step number for reporting
  logic [7:0] a_exp_q[$];
  int         a_id_q[$];
  logic [3:0] b_exp_q[$];
  int         b_id_q[$];

  // Reference state: plain integers updated with arithmetic from the behaviour rules
  int unsigned a_model = 0;
  int unsigned b_model = 0;
  bit          a_seen_reset = 1'b0;
  bit          b_seen_reset = 1'b0;
  int          a_step = 0;
  int          b_step = 0;

  sipo_shift_reg #(
    .WIDTH     (8),
    .SHIFT_LEFT(1'b1),
    .RESET_VAL (64'd0)
  ) u_dut_a (
    .clk  (clk),
    .reset(a_reset),
    .sin  (a_sin),
    .load (a_load),
    .d    (a_d),
    .q    (a_q)
  );

  sipo_shift_reg #(
    .WIDTH     (4),
    .SHIFT_LEFT(B_DIR == SHIFT_LEFT_E),
    .RESET_VAL (64'd0)
  ) u_dut_b (
    .clk  (clk),
    .reset(b_reset),
    .sin  (b_sin),
    .load (b_load),
    .d    (b_d),
    .q    (b_q)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Control inputs must never be unknown
  always @(posedge clk) begin
    a_ctrl_known : assert (!$isunknown({a_reset, a_load, b_reset, b_load}))
      else $error("FAIL ctrl_known: reset/load carry X");
  end

  // Monitor: after each edge, compare q against the oldest pending expectation
  always @(negedge clk) begin
    logic [7:0] ea;
    logic [3:0] eb;
    int         id;
    if (a_exp_q.size() > 0) begin
      ea = a_exp_q.pop_front();
      id = a_id_q.pop_front();
      checks++;
      if (a_q !== ea) begin
        errors++;
        $display("FAIL a_q step %0d: got %h expected %h", id, a_q, ea);
      end
    end
    if (b_exp_q.size() > 0) begin
      eb = b_exp_q.pop_front();
      id = b_id_q.pop_front();
      checks++;
      if (b_q !== eb) begin
        errors++;
        $display("FAIL b_q step %0d: got %h expected %h", id, b_q, eb);
      end
    end
  end

  // Drive one edge of the 8-bit left instance; use_c selects a hand-written expectation
  task automatic step_a(input bit r, input bit l, input logic [7:0] dd, input bit s,
                        input bit use_c, input logic [7:0] c);
    @(negedge clk);
    #1;
    a_reset = r;
    a_load  = l;
    a_d     = dd;
    a_sin   = s;
    if (!r) begin
      a_model      = 0;
      a_seen_reset = 1'b1;
    end else if (l) begin
      a_model = dd;
    end else begin
      a_model = (a_model * 2 + s) % 256;
    end
    a_step++;
    if (a_seen_reset) begin
      a_exp_q.push_back(use_c ? c : a_model[7:0]);
      a_id_q.push_back(a_step);
    end
  endtask

  // Drive one edge of the 4-bit right instance
  task automatic step_b(input bit r, input bit l, input logic [3:0] dd, input bit s,
                        input bit use_c, input logic [3:0] c);
    @(negedge clk);
    #1;
    b_reset = r;
    b_load  = l;
    b_d     = dd;
    b_sin   = s;
    if (!r) begin
      b_model      = 0;
      b_seen_reset = 1'b1;
    end else if (l) begin
      b_model = dd;
    end else begin
      b_model = b_model / 2 + s * 8;
    end
    b_step++;
    if (b_seen_reset) begin
      b_exp_q.push_back(use_c ? c : b_model[3:0]);
      b_id_q.push_back(b_step);
    end
  endtask

  // Stimulus
  initial begin
    logic [7:0] rd;
    int         wait_cycles;

    // Reset beats load
    step_a(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00);
    // Serial fill
    step_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01);
    step_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02);
    step_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05);
    step_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0A);
    // Parallel load ignores sin, then shift resumes
    step_a(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA);
    step_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h54);
    // Walk a single one to the MSB and out
    step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    step_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01);
    for (int i = 1; i < 8; i++) begin
      rd = 8'h01 << i;
      step_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, rd);
    end
    step_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    // Mid-stream reset discards shifted data
    step_a(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C);
    step_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h79);
    step_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hF3);
    step_a(1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00);
    step_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01);
    // Back-to-back loads: each edge takes the current d
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      step_a(1'b1, 1'b1, rd, 1'($urandom), 1'b1, rd);
    end
    // Randomised traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step_a(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
             8'($urandom), 1'($urandom), 1'b0, 8'h00);
    end
    a_reset = 1'b1;
    a_load  = 1'b0;

    // Right-shifting 4-bit instance
    step_b(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 4'h0);
    step_b(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h8);
    step_b(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hC);
    step_b(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h6);
    step_b(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hB);
    step_b(1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 4'h9);
    step_b(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h4);
    for (int i = 0; i < 200; i++) begin
      step_b(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
             4'($urandom), 1'($urandom), 1'b0, 4'h0);
    end

    // Let the monitor drain, bounded
    wait_cycles = 0;
    while ((a_exp_q.size() > 0 || b_exp_q.size() > 0) && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    checks++;
    if (a_exp_q.size() + b_exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", a_exp_q.size() + b_exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sipo_shift_reg
